period_generator: RTL and testbench
===================================

PERIOD_GENERATOR -- requirements
Module: period_generator

Interface
REQ-001 Parameter PERIOD_W, default 16: width of period_i and the internal period down-counter.
REQ-002 Parameter BURST_W, default 8: width of num_ticks_i and tick_count_o.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request to begin generation; sampled only in IDLE.
REQ-006 stop_i  input  1  abort request; sampled only in RUN.
REQ-007 period_i  input  PERIOD_W  tick period in clk_i cycles; latched on start accept.
REQ-008 num_ticks_i  input  BURST_W  burst length; latched on start accept; 0 = continuous.
REQ-009 tick_o  output  1  single-cycle tick pulse.
REQ-010 busy_o  output  1  high whenever state != IDLE.
REQ-011 done_o  output  1  single-cycle pulse on burst completion.
REQ-012 tick_count_o  output  BURST_W  ticks emitted since last accepted start.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 Start accept: IDLE and start_i=1 at an edge -> RUN next cycle; period_q <= max(period_i,1); burst_q <= num_ticks_i; cnt <= max(period_i,1)-1; tick_count_o <= 0.
REQ-015 A period_i of 0 SHALL be treated as 1 (tick every cycle).
REQ-016 In RUN with cnt != 0 and stop_i=0: cnt decrements by 1; tick_o=0.
REQ-017 In RUN with cnt == 0 and stop_i=0: tick_o=1 that cycle; cnt reloads period_q-1; tick_count_o increments (wraps at 2^BURST_W).
REQ-018 The first tick_o SHALL occur P cycles after the accept edge (P = latched period); subsequent ticks exactly P cycles apart.
REQ-019 Burst end: on the tick where burst_q != 0 and tick_count_o+1 == burst_q -> DONE next cycle.
REQ-020 burst_q == 0 SHALL run indefinitely until stop_i or reset.
REQ-021 DONE: done_o=1 for exactly one cycle, tick_o=0, then IDLE unconditionally; start_i in DONE ignored.
REQ-022 stop_i=1 in RUN -> IDLE next cycle; no done_o; tick_o forced 0 that cycle even if cnt == 0 (stop wins).
REQ-023 start_i in RUN and stop_i in IDLE/DONE SHALL have no effect.
REQ-024 period_i/num_ticks_i changes after accept SHALL not affect the active run.
REQ-025 tick_count_o SHALL hold its value in IDLE and DONE until the next accept.
REQ-026 tick_o and done_o SHALL be decoded from registered state, plus stop_i for tick_o only.

Reset
REQ-027 On reset_ni=0 (asynchronous): state=IDLE, cnt=0, period_q=1, burst_q=0, tick_count_o=0.
REQ-028 During and after reset: tick_o=0, done_o=0, busy_o=0.
REQ-029 Reset mid-RUN SHALL abort immediately with no done_o; first cycle after release is IDLE.

Structure
REQ-030 Shared package period_gen_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and default PERIOD_W/BURST_W constants.
REQ-031 Single flat module (registers + next-state block + output decode); no sub-module required.

Verification
REQ-032 Burst: period_i=5, num_ticks_i=3, start at edge 0 -> tick_o at cycles 5, 10, 15; done_o at 16; busy_o low from 17; tick_count_o=3 held.
REQ-033 Period edge cases: period_i=0 and period_i=1 with num_ticks_i=4 -> tick_o every cycle, cycles 1-4; done_o at 5.
REQ-034 Continuous + stop: period_i=3, num_ticks_i=0, stop_i asserted on the cycle of the 4th tick (cycle 12) -> no tick at 12; IDLE at 13; no done_o; tick_count_o=3.
REQ-035 Ignored inputs: start_i pulsed during RUN and period_i changed mid-run -> spacing unchanged; start_i during DONE -> not accepted, IDLE after.
REQ-036 Async reset: reset_ni low between edges during RUN (period_i=100) -> outputs 0 immediately; tick_count_o=0; new start after release -> first tick 100 cycles later.
REQ-037 Wrap: BURST_W=8, num_ticks_i=0, period_i=1, 300 cycles -> tick_count_o wraps 255->0; no done_o.

Source files
------------

// File: rtl/period_gen_pkg.sv
// Shared types and default widths for the period generator.
package period_gen_pkg;

  localparam int PERIOD_W_DEFAULT = 16;
  localparam int BURST_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/period_generator.sv
// Programmable tick generator: emits tick_o every period cycles, either for a
// fixed burst (followed by a one-cycle done_o) or continuously until stop_i.
module period_generator
  import period_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT,
  parameter int BURST_W  = BURST_W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [BURST_W-1:0]  num_ticks_i,
  output logic                tick_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [BURST_W-1:0]  tick_count_o,
  output logic [1:0]          state_o
);

  // Handshake: start_i is a level request accepted on any edge seen in IDLE;
  // stop_i is honoured only in RUN and wins over a tick due that same cycle.

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  tick_count_q, tick_count_d;

  logic [PERIOD_W-1:0] eff_period;
  logic [BURST_W-1:0]  count_inc;
  logic                tick_due;

  assign eff_period = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign count_inc  = tick_count_q + BURST_W'(1);
  assign tick_due   = (state_q == RUN) && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= PERIOD_W'(1);
      burst_q      <= '0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      burst_q      <= burst_d;
      tick_count_q <= tick_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    burst_d      = burst_q;
    tick_count_d = tick_count_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = RUN;
          period_d     = eff_period;
          burst_d      = num_ticks_i;
          cnt_d        = eff_period - PERIOD_W'(1);
          tick_count_d = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (tick_due) begin
          cnt_d        = period_q - PERIOD_W'(1);
          tick_count_d = count_inc;
          // A zero burst length never matches, so continuous mode runs on.
          if ((burst_q != '0) && (count_inc == burst_q)) begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tick_o       = tick_due && !stop_i;
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign tick_count_o = tick_count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_period_generator.sv
// Self-checking bench for period_generator: vector table, hand-written corner
// sequences and random runs, all checked against a cycle-count reference model.
module tb_period_generator;

  localparam int PW = 16;
  localparam int BW = 8;

  logic          clk;
  logic          reset_ni;
  logic          start_i;
  logic          stop_i;
  logic [PW-1:0] period_i;
  logic [BW-1:0] num_ticks_i;
  logic          tick_o;
  logic          busy_o;
  logic          done_o;
  logic [BW-1:0] tick_count_o;
  logic [1:0]    state_o;

  period_generator #(.PERIOD_W(PW), .BURST_W(BW)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .period_i    (period_i),
    .num_ticks_i (num_ticks_i),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tick_count_o(tick_count_o),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 burst finished. m_c is the cycle number since
  // the accepting edge; a tick falls on every multiple of the latched period.
  int m_mode, m_c, m_p, m_b, m_cnt;
  logic last_tick, last_done;
  int   last_c;
  logic [BW-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_c = 0; m_p = 1; m_b = 0; m_cnt = 0;
  endtask

  // One clock slot: drive inputs, check outputs against the model, advance.
  task automatic slot(input logic st, input logic sp, input int p, input int nt);
    logic e_tick;
    start_i = st; stop_i = sp; period_i = PW'(p); num_ticks_i = BW'(nt);
    #1;
    e_tick = (m_mode == 1) && !sp && (m_c % m_p == 0);
    chk("tick_o", tick_o, e_tick);
    chk("done_o", done_o, m_mode == 2);
    chk("busy_o", busy_o, m_mode != 0);
    chk("tick_count_o", tick_count_o, m_cnt);
    last_tick = tick_o;
    last_done = done_o;
    last_c    = m_c;
    case (m_mode)
      0: if (st) begin
           m_mode = 1; m_p = (p == 0) ? 1 : p; m_b = nt; m_c = 1; m_cnt = 0;
         end
      1: if (sp) m_mode = 0;
         else begin
           if (e_tick) begin
             m_cnt = (m_cnt + 1) % (1 << BW);
             if (m_b != 0 && m_cnt == m_b) m_mode = 2;
           end
           m_c++;
         end
      default: m_mode = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int period;
    int num_ticks;
    int run_slots;
    int exp_ticks;
    int exp_done_c;
    int exp_count;
  } vec_t;

  vec_t vecs[6];

  int ticks_seen, done_c, first_c, cap_cnt;
  logic saw_wrap, any_done;
  logic [BW-1:0] prev_cnt;

  initial begin
    vecs[0] = '{5, 3, 20, 3, 16, 3};
    vecs[1] = '{0, 4,  8, 4,  5, 4};
    vecs[2] = '{1, 4,  8, 4,  5, 4};
    vecs[3] = '{2, 2,  6, 2,  5, 2};
    vecs[4] = '{4, 1,  7, 1,  5, 1};
    vecs[5] = '{3, 0, 10, 3,  0, 3};

    // reset
    reset_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; period_i = '0; num_ticks_i = '0;
    model_reset();
    #1;
    chk("rst_tick", tick_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", tick_count_o, 0);
    repeat (2) @(posedge clk);
    #3 reset_ni = 1'b1;
    @(posedge clk);
    #1;

    // table-driven bursts
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      for (int k = 1; k <= vecs[v].exp_ticks; k++)
        exp_q.push_back(BW'(k * ((vecs[v].period == 0) ? 1 : vecs[v].period)));
      ticks_seen = 0; done_c = 0;
      slot(1'b1, 1'b0, vecs[v].period, vecs[v].num_ticks);
      for (int i = 0; i < vecs[v].run_slots; i++) begin
        slot(1'b0, 1'b0, vecs[v].period, vecs[v].num_ticks);
        if (last_tick) begin
          ticks_seen++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL vec%0d_extra_tick: got tick at cycle %0d expected none", v, last_c);
          end else chk($sformatf("vec%0d_tick_cycle", v), last_c, exp_q.pop_front());
        end
        if (last_done) done_c = last_c;
      end
      chk($sformatf("vec%0d_ticks", v), ticks_seen, vecs[v].exp_ticks);
      chk($sformatf("vec%0d_done_cycle", v), done_c, vecs[v].exp_done_c);
      chk($sformatf("vec%0d_count", v), tick_count_o, vecs[v].exp_count);
      chk($sformatf("vec%0d_queue_empty", v), exp_q.size(), 0);
      slot(1'b0, 1'b1, 0, 0);
      slot(1'b0, 1'b0, 0, 0);
    end

    // continuous run stopped on the cycle of the 4th tick
    slot(1'b1, 1'b0, 3, 0);
    for (int i = 1; i <= 11; i++) slot(1'b0, 1'b0, 3, 0);
    start_i = 1'b0; stop_i = 1'b1; #1;
    chk("stop_wins_tick", tick_o, 0);
    slot(1'b0, 1'b1, 3, 0);
    chk("stop_idle", busy_o, 0);
    chk("stop_no_done", done_o, 0);
    chk("stop_count", tick_count_o, 3);
    slot(1'b0, 1'b0, 0, 0);

    // start/period changes during RUN and start during DONE are ignored
    slot(1'b1, 1'b0, 4, 3);
    ticks_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      slot(i == 2 || i == 7, 1'b0, 7, 9);
      if (last_tick) begin
        ticks_seen++;
        chk("ign_spacing", last_c, ticks_seen * 4);
      end
    end
    chk("ign_ticks", ticks_seen, 3);
    slot(1'b1, 1'b0, 4, 3);
    chk("ign_done_seen", last_done, 1);
    chk("ign_start_in_done", busy_o, 0);
    slot(1'b0, 1'b0, 4, 3);
    chk("ign_still_idle", busy_o, 0);

    // asynchronous reset mid-run, then a fresh start
    slot(1'b1, 1'b0, 100, 0);
    for (int i = 0; i < 30; i++) slot(1'b0, 1'b0, 100, 0);
    #2 reset_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_tick", tick_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_count", tick_count_o, 0);
    #1 reset_ni = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_idle_after", busy_o, 0);
    slot(1'b1, 1'b0, 100, 0);
    first_c = 0;
    for (int i = 0; i < 100; i++) begin
      slot(1'b0, 1'b0, 100, 0);
      if (last_tick && first_c == 0) first_c = last_c;
    end
    chk("arst_first_tick", first_c, 100);
    slot(1'b0, 1'b1, 0, 0);

    // tick counter wrap in continuous mode
    slot(1'b1, 1'b0, 1, 0);
    saw_wrap = 1'b0; any_done = 1'b0; prev_cnt = '0;
    for (int i = 0; i < 300; i++) begin
      slot(1'b0, 1'b0, 1, 0);
      if (prev_cnt == 8'd255 && tick_count_o == 8'd0) saw_wrap = 1'b1;
      if (last_done) any_done = 1'b1;
      prev_cnt = tick_count_o;
    end
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_no_done", any_done, 0);
    chk("wrap_count", tick_count_o, 300 % 256);
    slot(1'b0, 1'b1, 0, 0);

    // random stimulus
    for (int t = 0; t < 40; t++) begin
      int rp, rn;
      rp = $urandom_range(0, 6);
      rn = $urandom_range(0, 4);
      for (int i = 0; i < 30; i++) begin
        slot($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 1) ? rp : $urandom_range(0, 9), rn);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
